// File: rtl/pcie_tx_pkg.sv
// Shared types and constants for the PCIe transmit-side arbitration blocks.
package pcie_tx_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_e;

  localparam int TLP_DW      = 16;
  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/pcie_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; the first set request found
// searching upward from ptr+1 (modulo N) wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          valid
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    // Scan farthest to nearest so the nearest candidate is the last one written.
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        onehot = '0;
        onehot[(int'(ptr) + k) % N] = 1'b1;
        idx   = PW'((int'(ptr) + k) % N);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Round-robin arbiter sharing the PCIe VC0 transmit TLP interface between NREQ sources.
// Optional REQ-phase timeout is built when PCIE_TX_TIMEOUT_EN is defined.
module pcie_tx_arbiter
  import pcie_tx_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DW         = TLP_DW,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dl_up_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    st_i,
  input  logic [NREQ-1:0]    end_i,
  input  logic [NREQ*DW-1:0] data_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rdy_o,
  output logic               tx_req_o,
  input  logic               tx_rdy_i,
  output logic [DW-1:0]      tx_data_o,
  output logic               tx_st_o,
  output logic               tx_end_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || GAP_CYCLES < 0 || GAP_CYCLES > 7 || TIMEOUT < 2) begin : g_param_chk
    $error("pcie_tx_arbiter: parameter out of range");
  end

  state_e          state, state_n;
  logic [NREQ-1:0] gnt, gnt_n;
  logic [PW-1:0]   gidx, gidx_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic            txreq, txreq_n;
  logic [2:0]      gcnt, gcnt_n;

  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_vld;
  logic            acc;

`ifdef PCIE_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt, tcnt_n;
  logic          to_q, to_n;
`endif

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req    (req_i),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    gidx_n  = gidx;
    ptr_n   = ptr;
    txreq_n = txreq;
    gcnt_n  = gcnt;
`ifdef PCIE_TX_TIMEOUT_EN
    tcnt_n  = tcnt;
    to_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (dl_up_i && pick_vld) begin
          gnt_n   = pick_oh;
          gidx_n  = pick_idx;
          txreq_n = 1'b1;
          state_n = REQ;
`ifdef PCIE_TX_TIMEOUT_EN
          tcnt_n  = TW'(TIMEOUT - 1);
`endif
        end
      end
      REQ: begin
        // A withdrawn request or link drop abandons without moving the pointer.
        if (!dl_up_i || !req_i[gidx]) begin
          gnt_n   = '0;
          txreq_n = 1'b0;
          state_n = IDLE;
        end else if (tx_rdy_i) begin
          state_n = XFER;
        end
`ifdef PCIE_TX_TIMEOUT_EN
        else if (tcnt == '0) begin
          gnt_n   = '0;
          txreq_n = 1'b0;
          ptr_n   = gidx;
          to_n    = 1'b1;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt - 1'b1;
        end
`endif
      end
      XFER: begin
        if (tx_rdy_i) begin
          txreq_n = 1'b0;
          if (end_i[gidx]) begin
            ptr_n   = gidx;
            gnt_n   = '0;
            gcnt_n  = 3'(GAP_CYCLES - 1);
            state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (gcnt == '0) state_n = IDLE;
        else            gcnt_n  = gcnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      gidx  <= '0;
      ptr   <= PW'(NREQ - 1);
      txreq <= 1'b0;
      gcnt  <= '0;
`ifdef PCIE_TX_TIMEOUT_EN
      tcnt  <= '0;
      to_q  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      gidx  <= gidx_n;
      ptr   <= ptr_n;
      txreq <= txreq_n;
      gcnt  <= gcnt_n;
`ifdef PCIE_TX_TIMEOUT_EN
      tcnt  <= tcnt_n;
      to_q  <= to_n;
`endif
    end
  end

  assign acc       = (state == XFER) && tx_rdy_i;
  assign rdy_o     = acc ? gnt : '0;
  assign tx_data_o = acc ? data_i[gidx*DW +: DW] : '0;
  assign tx_st_o   = acc && st_i[gidx];
  assign tx_end_o  = acc && end_i[gidx];
  assign gnt_o     = gnt;
  assign tx_req_o  = txreq;
  assign busy_o    = (state != IDLE);

`ifdef PCIE_TX_TIMEOUT_EN
  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Scoreboard bench for pcie_tx_arbiter: requester models feed random TLPs, a
// round-robin reference predicts the beat stream, and a monitor checks it.
module tb_pcie_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int GAP  = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               dl_up_i;
  logic [NREQ-1:0]    req_i, st_i, end_i;
  logic [NREQ*DW-1:0] data_i;
  logic [NREQ-1:0]    gnt_o, rdy_o;
  logic               tx_req_o, tx_rdy_i;
  logic [DW-1:0]      tx_data_o;
  logic               tx_st_o, tx_end_o, busy_o, timeout_o;

  always #4 clk = ~clk;

  pcie_tx_arbiter #(.NREQ(NREQ), .DW(DW), .GAP_CYCLES(GAP), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .dl_up_i   (dl_up_i),
    .req_i     (req_i),
    .st_i      (st_i),
    .end_i     (end_i),
    .data_i    (data_i),
    .gnt_o     (gnt_o),
    .rdy_o     (rdy_o),
    .tx_req_o  (tx_req_o),
    .tx_rdy_i  (tx_rdy_i),
    .tx_data_o (tx_data_o),
    .tx_st_o   (tx_st_o),
    .tx_end_o  (tx_end_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic          st;
    logic          en;
  } beat_t;

  beat_t         exp_q[$];
  int            nchk = 0, nerr = 0;
  logic [DW-1:0] bdata [NREQ][8];
  int            blen [NREQ];
  int            bidx [NREQ];
  bit            pend [NREQ];
  int            mptr;
  int            cyc = 0, last_end = 0;
  bit            more = 0, drop_chk = 0;
  logic          prev_txreq = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_i[i]            = pend[i];
      data_i[i*DW +: DW]  = pend[i] ? bdata[i][bidx[i]] : '0;
      st_i[i]             = pend[i] && (bidx[i] == 0);
      end_i[i]            = pend[i] && (bidx[i] == blen[i] - 1);
    end
  endtask

  // One clock: note which requesters had a beat accepted, then advance them.
  task automatic cycle();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = rdy_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && pend[i]) begin
        bidx[i]++;
        if (bidx[i] == blen[i]) begin
          pend[i] = 0;
          bidx[i] = 0;
        end
      end
    end
    drive();
  endtask

  task automatic load(input int i, input int len);
    blen[i] = len;
    bidx[i] = 0;
    pend[i] = 1;
    for (int b = 0; b < len; b++) bdata[i][b] = DW'($urandom);
  endtask

  // Reference: with a fixed pending set, service order is simply cyclic from ptr+1.
  task automatic push_round(input logic [NREQ-1:0] mask);
    int last;
    beat_t e;
    last = mptr;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (mptr + k) % NREQ;
      if (mask[i]) begin
        for (int b = 0; b < blen[i]; b++) begin
          e.id   = i;
          e.data = bdata[i][b];
          e.st   = (b == 0);
          e.en   = (b == blen[i] - 1);
          exp_q.push_back(e);
        end
        last = i;
      end
    end
    mptr = last;
  endtask

  function automatic bit any_pend();
    bit r = 0;
    for (int i = 0; i < NREQ; i++) r |= pend[i];
    return r;
  endfunction

  task automatic drain(input int limit);
    int n = 0;
    while ((any_pend() || exp_q.size() > 0) && n < limit) begin
      cycle();
      tx_rdy_i = ($urandom_range(99) < 70);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      beat_t e;
      logic [NREQ-1:0] eg;
      cyc++;
      if (drop_chk) begin
        chk("tx_req_drop", tx_req_o, 0);
        drop_chk = 0;
      end
      if (|rdy_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", rdy_o, 0);
        end else begin
          e  = exp_q.pop_front();
          eg = '0;
          eg[e.id] = 1'b1;
          chk("beat_gnt", gnt_o, eg);
          chk("beat_rdy", rdy_o, eg);
          chk("beat_data", tx_data_o, e.data);
          chk("beat_st_end", {tx_st_o, tx_end_o}, {e.st, e.en});
        end
        if (tx_st_o) drop_chk = 1;
        if (tx_end_o) begin
          last_end = cyc;
          more     = (exp_q.size() > 0);
        end
      end else begin
        chk("idle_bus", {timeout_o, tx_st_o, tx_end_o, tx_data_o}, 0);
      end
      if (tx_req_o && !prev_txreq && more) begin
        chk("gap_len", 64'(cyc - last_end), 64'(GAP + 2));
        more = 0;
      end
      prev_txreq = tx_req_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic [NREQ-1:0] mask, eg;

    rst = 1'b1;
    dl_up_i = 1'b1;
    tx_rdy_i = 1'b0;
    mptr = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; bidx[i] = 0; blen[i] = 1;
    end
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_txreq_busy_to", {tx_req_o, busy_o, timeout_o}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single 4-beat TLP from requester 1, tx_rdy two cycles after tx_req.
    load(1, 4);
    push_round(4'b0010);
    drive();
    cycle();
    chk("t1_gnt", gnt_o, 4'b0010);
    chk("t1_txreq_busy", {tx_req_o, busy_o}, 2'b11);
    cycle();
    cycle();
    tx_rdy_i = 1'b1;
    n = 0;
    while (pend[1] && n < 20) begin cycle(); n++; end
    chk("t1_done", 64'(exp_q.size()), 0);
    chk("t1_gap_state", {busy_o, tx_req_o, gnt_o}, {1'b1, 1'b0, 4'b0000});
    cycle();
    chk("t1_idle", busy_o, 0);

    // Link down blocks grants; a drop in REQ abandons without moving the pointer.
    tx_rdy_i = 1'b0;
    dl_up_i  = 1'b0;
    for (int i = 0; i < NREQ; i++) load(i, 2);
    drive();
    repeat (4) begin
      cycle();
      chk("dl_down_nogrant", {tx_req_o, gnt_o}, 0);
    end
    eg = '0;
    eg[(mptr + 1) % NREQ] = 1'b1;
    dl_up_i = 1'b1;
    cycle();
    chk("dl_up_grant", gnt_o, eg);
    cycle();
    chk("req_hold", {tx_req_o, gnt_o}, {1'b1, eg});
    dl_up_i = 1'b0;
    cycle();
    chk("dl_drop_abort", {tx_req_o, gnt_o}, 0);
    dl_up_i = 1'b1;
    cycle();
    chk("ptr_unchanged", gnt_o, eg);
    push_round(4'b1111);
    drain(2000);

    // Randomized rounds: random pending sets, lengths, data and tx_rdy stalls.
    repeat (40) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) if (mask[i]) load(i, $urandom_range(1, 5));
      push_round(mask);
      drive();
      drain(2000);
    end

    // Reset in the middle of a TLP.
    load(3, 6);
    push_round(4'b1000);
    drive();
    tx_rdy_i = 1'b1;
    n = 0;
    while (bidx[3] < 2 && n < 50) begin cycle(); n++; end
    chk("rst_mid_reached", 64'(bidx[3]), 2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_gnt_rdy", {gnt_o, rdy_o}, 0);
    chk("rst_mid_tx", {tx_req_o, tx_st_o, tx_end_o, tx_data_o}, 0);
    chk("rst_mid_busy_to", {busy_o, timeout_o}, 0);
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; bidx[i] = 0; end
    mptr = NREQ - 1;
    more = 0;
    drop_chk = 0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NREQ; i++) load(i, $urandom_range(1, 3));
    push_round(4'b1111);
    drive();
    cycle();
    chk("post_rst_first", gnt_o, 4'b0001);
    drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
